// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: access size encodings, FSM state
// type and alignment helpers used by both the FSM and the lane logic.
package load_store_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2
  } lsu_state_e;

  // Size 2'b11 behaves as a word everywhere.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] adr_lo);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~adr_lo[0];
      default: return (adr_lo == 2'b00);
    endcase
  endfunction

  function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] adr_lo);
    case (size)
      SZ_BYTE: return adr_lo;
      SZ_HALF: return {adr_lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_lane_merge.sv
// Little-endian lane handling: extracts and extends load data from a memory
// word, and builds a store word with only the addressed lanes replaced.
module lane_merge
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        sign_ext_i,
  input  logic [1:0]  adr_lo_i,
  input  logic [31:0] rd_word_i,
  input  logic [31:0] merge_word_i,
  input  logic [31:0] wr_data_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_word_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (adr_lo_i)
      2'd0: byte_sel = rd_word_i[7:0];
      2'd1: byte_sel = rd_word_i[15:8];
      2'd2: byte_sel = rd_word_i[23:16];
      2'd3: byte_sel = rd_word_i[31:24];
    endcase
    half_sel = adr_lo_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];
  end

  always_comb begin
    ld_data_o = rd_word_i;
    st_word_o = wr_data_i;
    case (size_i)
      SZ_BYTE: begin
        ld_data_o = {{24{sign_ext_i & byte_sel[7]}}, byte_sel};
        st_word_o = merge_word_i;
        case (adr_lo_i)
          2'd0: st_word_o[7:0]   = wr_data_i[7:0];
          2'd1: st_word_o[15:8]  = wr_data_i[7:0];
          2'd2: st_word_o[23:16] = wr_data_i[7:0];
          2'd3: st_word_o[31:24] = wr_data_i[7:0];
        endcase
      end
      SZ_HALF: begin
        ld_data_o = {{16{sign_ext_i & half_sel[15]}}, half_sel};
        st_word_o = merge_word_i;
        if (adr_lo_i[1]) st_word_o[31:16] = wr_data_i[15:0];
        else             st_word_o[15:0]  = wr_data_i[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: latches a request, accesses a word-addressed memory, and
// performs read-modify-write for sub-word stores.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Req,
  input  logic        WrEn,
  input  logic [1:0]  Size,
  input  logic        SignExt,
  input  logic [31:0] Adr,
  input  logic [31:0] WrData,
  output logic        Busy,
  output logic        Done,
  output logic        Misalign,
  output logic [31:0] RdData,
  output logic        MemWr,
  output logic [31:0] MemAdr,
  output logic [31:0] MemDataIn,
  input  logic [31:0] MemDataOut
);

  lsu_state_e  state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic        wr_en_q, wr_en_d;
  logic [1:0]  size_q, size_d;
  logic        sign_ext_q, sign_ext_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        done_q, done_d;
  logic        misalign_q, misalign_d;
  logic        mem_wr_raw;
  logic [31:0] ld_data;
  logic [31:0] st_word;

  lane_merge u_lane_merge (
    .size_i      (size_q),
    .sign_ext_i  (sign_ext_q),
    .adr_lo_i    (adr_q[1:0]),
    .rd_word_i   (MemDataOut),
    .merge_word_i(merge_q),
    .wr_data_i   (wr_data_q),
    .ld_data_o   (ld_data),
    .st_word_o   (st_word)
  );

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    wr_en_d    = wr_en_q;
    size_d     = size_q;
    sign_ext_d = sign_ext_q;
    wr_data_d  = wr_data_q;
    merge_d    = merge_q;
    rd_data_d  = rd_data_q;
    done_d     = 1'b0;
    misalign_d = 1'b0;
    mem_wr_raw = 1'b0;
    case (state_q)
      IDLE: begin
        if (Req) begin
          adr_d      = Adr;
          wr_en_d    = WrEn;
          size_d     = Size;
          sign_ext_d = SignExt;
          wr_data_d  = WrData;
          // Rejected requests complete straight from IDLE; the fields are
          // still latched but nothing downstream consumes them.
          if (MISALIGN_EN && !is_aligned(Size, Adr[1:0])) begin
            done_d     = 1'b1;
            misalign_d = 1'b1;
          end else begin
            if (!MISALIGN_EN) adr_d[1:0] = align_lo(Size, Adr[1:0]);
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (!wr_en_q) begin
          rd_data_d = ld_data;
          done_d    = 1'b1;
          state_d   = IDLE;
        end else if (size_q[1]) begin
          mem_wr_raw = 1'b1;
          done_d     = 1'b1;
          state_d    = IDLE;
        end else begin
          merge_d = MemDataOut;
          state_d = WRITE;
        end
      end
      WRITE: begin
        mem_wr_raw = 1'b1;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= IDLE;
      adr_q      <= '0;
      wr_en_q    <= 1'b0;
      size_q     <= '0;
      sign_ext_q <= 1'b0;
      wr_data_q  <= '0;
      merge_q    <= '0;
      rd_data_q  <= '0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      wr_en_q    <= wr_en_d;
      size_q     <= size_d;
      sign_ext_q <= sign_ext_d;
      wr_data_q  <= wr_data_d;
      merge_q    <= merge_d;
      rd_data_q  <= rd_data_d;
      done_q     <= done_d;
      misalign_q <= misalign_d;
    end
  end

  // Gating by Reset keeps an in-flight write from landing on the reset edge.
  assign MemWr     = mem_wr_raw & ~Reset;
  assign MemAdr    = {adr_q[31:2], 2'b00};
  assign MemDataIn = (state_q == WRITE) ? st_word : wr_data_q;
  assign Busy      = (state_q != IDLE);
  assign Done      = done_q;
  assign Misalign  = misalign_q;
  assign RdData    = rd_data_q;

endmodule
